group_serializer: RTL and testbench

- Write-side counterpart of the RAM bit-stream grouping path.
- Accepts GROUP_WIDTH-bit parallel groups over a valid/ready handshake and serialises each group into single-bit RAM writes, MSB first.
- Generates the write address and write enable itself.
- Raises frame_done once FRAME_BITS bits have been written; holds until restarted.

---
 rtl/group_serializer.sv | 127 ++++++++++++
 tb/tb_group_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/group_serializer.sv
// Serialises GROUP_WIDTH-bit groups into single-bit RAM writes with self-generated address/wren.
// Optional macro GROUP_LSB_FIRST_EN: write group_in[0] first instead of the MSB.
module group_serializer #(
  parameter int GROUP_WIDTH = 3,
  parameter int ADDR_WIDTH  = 15,
  parameter int FRAME_BITS  = 19200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_restart,
  input  logic [GROUP_WIDTH-1:0] group_in,
  input  logic                   group_valid,
  output logic                   group_ready,
  output logic                   bit_out,
  output logic                   wren,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   frame_done
);

  localparam int CNT_W = (GROUP_WIDTH > 1) ? $clog2(GROUP_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(GROUP_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [GROUP_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [GROUP_WIDTH-1:0]  shreg_next_s;
  logic                    group_end_s;
  logic                    xfer_s;

  assign group_end_s = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  // Back-to-back reload is only offered when this group does not close the frame.
  assign group_ready = ~reset & enable & ~frame_restart &
                       ((state_q == IDLE) | (group_end_s & (addr_q != LAST_ADDR)));
  assign xfer_s      = group_valid & group_ready;

`ifdef GROUP_LSB_FIRST_EN
  assign shreg_next_s = shreg_q >> 1;
  assign bit_out      = shreg_q[0];
`else
  assign shreg_next_s = shreg_q << 1;
  assign bit_out      = shreg_q[GROUP_WIDTH-1];
`endif

  assign wren       = ~reset & enable & (state_q == SHIFT);
  assign address    = addr_q;
  assign frame_done = (state_q == DONE);

  // Next-state, shift register, bit counter and address computation.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (frame_restart) begin
            addr_d = '0;
          end else if (xfer_s) begin
            shreg_d   = group_in;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          shreg_d   = shreg_next_s;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          addr_d    = addr_q + ADDR_WIDTH'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (addr_q == LAST_ADDR) begin
              addr_d  = '0;
              state_d = DONE;
            end else if (xfer_s) begin
              shreg_d = group_in;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          if (frame_restart) begin
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: tb/tb_group_serializer.sv
// Self-checking bench for group_serializer: directed vector table, hand sequences,
// and randomized stimulus against a queue-based reference model.
module tb_group_serializer;
  localparam int GW = 3;
  localparam int AW = 15;
  localparam int FB = 6;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          frame_restart;
  logic [GW-1:0] group_in;
  logic          group_valid;
  logic          group_ready;
  logic          bit_out;
  logic          wren;
  logic [AW-1:0] address;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  group_serializer #(.GROUP_WIDTH(GW), .ADDR_WIDTH(AW), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_restart(frame_restart),
    .group_in(group_in), .group_valid(group_valid), .group_ready(group_ready),
    .bit_out(bit_out), .wren(wren), .address(address), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          en;
    logic          rs;
    logic          vd;
    logic [GW-1:0] g;
    logic          e_rdy;
    logic          e_wren;
    logic          e_bit;
    int            e_addr;
    logic          e_done;
  } vec_t;

  vec_t tbl[$];

  // k-th bit written for group g (write order depends on build)
  function automatic logic pick(input logic [GW-1:0] g, input int k);
`ifdef GROUP_LSB_FIRST_EN
    return g[k];
`else
    return g[GW-1-k];
`endif
  endfunction

  task automatic add(input logic en, input logic rs, input logic vd, input logic [GW-1:0] g,
                     input logic rdy, input logic wr, input logic b, input int a, input logic dn);
    vec_t v;
    v.en = en; v.rs = rs; v.vd = vd; v.g = g;
    v.e_rdy = rdy; v.e_wren = wr; v.e_bit = b; v.e_addr = a; v.e_done = dn;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic rs, input logic vd,
                       input logic [GW-1:0] g);
    reset = rst; enable = en; frame_restart = rs; group_valid = vd; group_in = g;
  endtask

  // reference model state
  int   m_q[$];
  int   m_addr;
  bit   m_done;

  task automatic model_reset();
    m_q.delete();
    m_addr = 0;
    m_done = 1'b0;
  endtask

  function automatic bit model_ready(input bit en, input bit rs);
    bit open;
    open = (!m_done && m_q.size() == 0) || (m_q.size() == 1 && m_addr != FB - 1);
    return en && !rs && open;
  endfunction

  task automatic model_step(input bit en, input bit rs, input bit vd, input logic [GW-1:0] g);
    bit xfer;
    xfer = vd && model_ready(en, rs);
    if (en) begin
      if (m_done) begin
        if (rs) begin m_done = 1'b0; m_addr = 0; end
      end else if (m_q.size() == 0) begin
        if (rs) m_addr = 0;
        else if (xfer) for (int k = 0; k < GW; k++) m_q.push_back(int'(pick(g, k)));
      end else begin
        void'(m_q.pop_front());
        if (m_addr == FB - 1) begin
          m_addr = 0;
          m_done = 1'b1;
          m_q.delete();
        end else begin
          m_addr++;
        end
        if (m_q.size() == 0 && xfer)
          for (int k = 0; k < GW; k++) m_q.push_back(int'(pick(g, k)));
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    #3;
    chk("reset_ready", int'(group_ready), 1);
    chk("reset_wren", int'(wren), 0);
    chk("reset_addr", int'(address), 0);
    chk("reset_done", int'(frame_done), 0);
    chk("reset_bit", int'(bit_out), 0);
    @(posedge clk);
    #1;

    // single group 101
    add(1,0,1,3'b101, 1,0,0,0,0);
    add(1,0,0,3'b000, 0,1,pick(3'b101,0),0,0);
    add(1,0,0,3'b000, 0,1,pick(3'b101,1),1,0);
    add(1,0,0,3'b000, 1,1,pick(3'b101,2),2,0);
    add(1,0,0,3'b000, 1,0,0,3,0);
    // restart in IDLE, then back-to-back frame 110,011
    add(1,1,0,3'b000, 0,0,0,3,0);
    add(1,0,1,3'b110, 1,0,0,0,0);
    add(1,0,1,3'b011, 0,1,pick(3'b110,0),0,0);
    add(1,0,1,3'b011, 0,1,pick(3'b110,1),1,0);
    add(1,0,1,3'b011, 1,1,pick(3'b110,2),2,0);
    add(1,0,1,3'b011, 0,1,pick(3'b011,0),3,0);
    add(1,0,1,3'b011, 0,1,pick(3'b011,1),4,0);
    add(1,0,1,3'b011, 0,1,pick(3'b011,2),5,0);
    add(1,0,1,3'b011, 0,0,0,0,1);
    // restart from DONE, group 111
    add(1,1,0,3'b000, 0,0,0,0,1);
    add(1,0,1,3'b111, 1,0,0,0,0);
    add(1,0,0,3'b000, 0,1,pick(3'b111,0),0,0);
    add(1,0,0,3'b000, 0,1,pick(3'b111,1),1,0);
    add(1,0,0,3'b000, 1,1,pick(3'b111,2),2,0);
    // enable stall inside group 100
    add(1,0,1,3'b100, 1,0,0,3,0);
    add(1,0,0,3'b000, 0,1,pick(3'b100,0),3,0);
    add(0,0,0,3'b000, 0,0,0,4,0);
    add(0,0,0,3'b000, 0,0,0,4,0);
    add(1,0,0,3'b000, 0,1,pick(3'b100,1),4,0);
    add(1,0,0,3'b000, 0,1,pick(3'b100,2),5,0);
    add(1,0,1,3'b111, 0,0,0,0,1);
    // restart gated by enable, then effective restart
    add(0,1,0,3'b000, 0,0,0,0,1);
    add(1,0,0,3'b000, 0,0,0,0,1);
    add(1,1,0,3'b000, 0,0,0,0,1);
    add(1,0,0,3'b000, 1,0,0,0,0);
    add(1,0,1,3'b010, 1,0,0,0,0);
    add(1,0,0,3'b000, 0,1,pick(3'b010,0),0,0);

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].en, tbl[i].rs, tbl[i].vd, tbl[i].g);
      #3;
      chk($sformatf("vec%0d_ready", i), int'(group_ready), int'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_wren", i), int'(wren), int'(tbl[i].e_wren));
      chk($sformatf("vec%0d_addr", i), int'(address), tbl[i].e_addr);
      chk($sformatf("vec%0d_done", i), int'(frame_done), int'(tbl[i].e_done));
      if (tbl[i].e_wren) chk($sformatf("vec%0d_bit", i), int'(bit_out), int'(tbl[i].e_bit));
      @(posedge clk);
      #1;
    end

    // reset after the first bit of 010: group is abandoned
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    #3;
    chk("rstmid_wren", int'(wren), 0);
    chk("rstmid_addr", int'(address), 0);
    chk("rstmid_ready", int'(group_ready), 1);
    chk("rstmid_done", int'(frame_done), 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #4;
      chk("rstmid_idle_wren", int'(wren), 0);
    end
    @(posedge clk);
    #1;

    // randomized phase against the reference model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, r_en, r_rs, r_vd;
      logic [GW-1:0] r_g;
      bit e_rdy;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      r_rs  = ($urandom_range(0, 15) == 0);
      r_vd  = ($urandom_range(0, 2) != 0);
      r_g   = GW'($urandom);
      drive(r_rst, r_en, r_rs, r_vd, r_g);
      #3;
      if (!r_rst) begin
        e_rdy = model_ready(r_en, r_rs);
        chk("rnd_ready", int'(group_ready), int'(e_rdy));
        chk("rnd_wren", int'(wren), int'(r_en && m_q.size() != 0));
        chk("rnd_addr", int'(address), m_addr);
        chk("rnd_done", int'(frame_done), int'(m_done));
        if (m_q.size() != 0) chk("rnd_bit", int'(bit_out), m_q[0]);
      end
      @(posedge clk);
      if (r_rst) model_reset();
      else model_step(r_en, r_rs, r_vd, r_g);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
